// File: rtl/tinst_sched.sv
// Tensor-instruction scheduler: in-order queue of PRELOADA/PRELOADC/TMMA with A-tile-store hazard gating.
// Optional TINST_SCHED_PERF_EN adds a saturating hazard-stall counter output (stall_cnt_o).

`ifndef TINST_TYPE_TMMA
`define TINST_TYPE_TMMA 0
`endif
`ifndef TINST_TYPE_PRELOADA
`define TINST_TYPE_PRELOADA 1
`endif
`ifndef TINST_TYPE_PRELOADC
`define TINST_TYPE_PRELOADC 2
`endif

module tinst_sched #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int TYPE_WIDTH = 2,
    parameter int PREC_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [TYPE_WIDTH-1:0] in_type_i,
    input  logic [ADDR_WIDTH-1:0] in_addr0_i,
    input  logic [ADDR_WIDTH-1:0] in_addr1_i,
    input  logic [PREC_WIDTH-1:0] in_precision_i,
    input  logic                  in_acc_i,
    input  logic                  flush_i,
    output logic                  issue_tinst_valid_o,
    input  logic                  issue_tinst_ready_i,
    output logic [TYPE_WIDTH-1:0] issue_tinst_type_o,
    output logic [ADDR_WIDTH-1:0] issue_tinst_addr0_o,
    output logic [ADDR_WIDTH-1:0] issue_tinst_addr1_o,
    output logic [PREC_WIDTH-1:0] issue_tinst_precision_o,
    output logic                  issue_tinst_acc_o,
    output logic [1:0]            a_cnt_o,
    output logic                  err_o
`ifdef TINST_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [TYPE_WIDTH-1:0] T_TMMA = TYPE_WIDTH'(`TINST_TYPE_TMMA);
    localparam logic [TYPE_WIDTH-1:0] T_PA   = TYPE_WIDTH'(`TINST_TYPE_PRELOADA);
    localparam logic [TYPE_WIDTH-1:0] T_PC   = TYPE_WIDTH'(`TINST_TYPE_PRELOADC);

    typedef struct packed {
        logic [TYPE_WIDTH-1:0] typ;
        logic [ADDR_WIDTH-1:0] addr0;
        logic [ADDR_WIDTH-1:0] addr1;
        logic [PREC_WIDTH-1:0] prec;
        logic                  acc;
    } entry_t;

    entry_t      mem [DEPTH];
    entry_t      head;
    entry_t      in_entry;
    logic [PW:0] wr_ptr, rd_ptr;
    logic [1:0]  a_cnt;
    logic        full, empty, blocked, legal, push, pop;

    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[PW-1:0]];
    assign legal = (in_type_i == T_TMMA) || (in_type_i == T_PA) || (in_type_i == T_PC);

    // A-store hazard: no room for another A tile, or no A tile to consume
    assign blocked = ((head.typ == T_PA) && (a_cnt == 2'd2)) ||
                     ((head.typ == T_TMMA) && (a_cnt == 2'd0));

    assign in_ready_o          = !full && !flush_i;
    assign issue_tinst_valid_o = !empty && !blocked && !flush_i;
    assign push                = in_valid_i && in_ready_o;
    assign pop                 = issue_tinst_valid_o && issue_tinst_ready_i;

    assign in_entry = '{typ: in_type_i, addr0: in_addr0_i, addr1: in_addr1_i,
                        prec: in_precision_i, acc: in_acc_i};

    assign issue_tinst_type_o      = head.typ;
    assign issue_tinst_addr0_o     = head.addr0;
    assign issue_tinst_addr1_o     = head.addr1;
    assign issue_tinst_precision_o = head.prec;
    assign issue_tinst_acc_o       = head.acc;
    assign a_cnt_o                 = a_cnt;

    // Payload storage carries no reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push && legal)
            mem[wr_ptr[PW-1:0]] <= in_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            a_cnt  <= 2'd0;
            err_o  <= 1'b0;
        end else begin
            if (flush_i) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push && legal) wr_ptr <= wr_ptr + 1'b1;
                if (pop)           rd_ptr <= rd_ptr + 1'b1;
            end
            // Flush leaves a_cnt alone: the A buffers still hold their tiles
            if (pop) begin
                if (head.typ == T_PA)        a_cnt <= a_cnt + 2'd1;
                else if (head.typ == T_TMMA) a_cnt <= a_cnt - 2'd1;
            end
            if (push && !legal) err_o <= 1'b1;
        end
    end

`ifdef TINST_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt_o <= '0;
        else if (!empty && blocked && (stall_cnt_o != 32'hFFFF_FFFF))
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule
